// File: rtl/predicate_compare_arbiter_pkg.sv
// ============================================================================
// Module      : predicate_compare_arbiter_pkg
// Description : Opcode and predicate-flag encodings for the shared compare unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package predicate_compare_arbiter_pkg;

  localparam int OP_WIDTH    = 4;
  localparam int FLAGS_WIDTH = 10;

  // Each opcode value equals the bit index of its predicate in rsp_flags.
  localparam logic [OP_WIDTH-1:0] C_OP_EQ    = 4'd0;
  localparam logic [OP_WIDTH-1:0] C_OP_LT_U  = 4'd1;
  localparam logic [OP_WIDTH-1:0] C_OP_LTE_U = 4'd2;
  localparam logic [OP_WIDTH-1:0] C_OP_GT_U  = 4'd3;
  localparam logic [OP_WIDTH-1:0] C_OP_GTE_U = 4'd4;
  localparam logic [OP_WIDTH-1:0] C_OP_LT_S  = 4'd5;
  localparam logic [OP_WIDTH-1:0] C_OP_LTE_S = 4'd6;
  localparam logic [OP_WIDTH-1:0] C_OP_GT_S  = 4'd7;
  localparam logic [OP_WIDTH-1:0] C_OP_GTE_S = 4'd8;
  localparam logic [OP_WIDTH-1:0] C_OP_NE    = 4'd9;

  localparam int C_FLAG_EQ    = 0;
  localparam int C_FLAG_LT_U  = 1;
  localparam int C_FLAG_LTE_U = 2;
  localparam int C_FLAG_GT_U  = 3;
  localparam int C_FLAG_GTE_U = 4;
  localparam int C_FLAG_LT_S  = 5;
  localparam int C_FLAG_LTE_S = 6;
  localparam int C_FLAG_GT_S  = 7;
  localparam int C_FLAG_GTE_S = 8;
  localparam int C_FLAG_NE    = 9;

  function automatic logic op_is_reserved(input logic [OP_WIDTH-1:0] op);
    return (op > C_OP_NE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/predicate_compare_arbiter_rr_priority_arbiter.sv
// ============================================================================
// Module      : rr_priority_arbiter
// Description : Round-robin grant: first requester at or above the pointer wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_arbiter
  import predicate_compare_arbiter_pkg::*;
#(
  parameter  int REQUESTERS = 4,
  localparam int ID_WIDTH   = $clog2(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] i_req,
  input  logic                  i_enable,
  input  logic [ID_WIDTH-1:0]   i_pointer,
  output logic [REQUESTERS-1:0] o_grant,
  output logic [ID_WIDTH-1:0]   o_grant_id,
  output logic                  o_grant_valid
);

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    int                  w_idx;
    logic [ID_WIDTH-1:0] w_sel;
    o_grant       = '0;
    o_grant_id    = '0;
    o_grant_valid = 1'b0;
    w_idx         = 0;
    w_sel         = '0;
    for (int k = REQUESTERS - 1; k >= 0; k--) begin
      w_idx = int'(i_pointer) + k;
      if (w_idx >= REQUESTERS) w_idx = w_idx - REQUESTERS;
      w_sel = ID_WIDTH'(w_idx);
      if (i_enable && i_req[w_sel]) begin
        o_grant        = '0;
        o_grant[w_sel] = 1'b1;
        o_grant_id     = w_sel;
        o_grant_valid  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/predicate_compare_arbiter.sv
// ============================================================================
// Module      : predicate_compare_arbiter
// Description : Round-robin shared compare unit, operand stage then response stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module predicate_compare_arbiter
  import predicate_compare_arbiter_pkg::*;
#(
  parameter  int WORD_WIDTH = 32,
  parameter  int REQUESTERS = 4,
  localparam int ID_WIDTH   = $clog2(REQUESTERS)
) (
  input  logic                           clock,
  input  logic                           clear_n,
  input  logic [REQUESTERS-1:0]          req_valid,
  output logic [REQUESTERS-1:0]          req_ready,
  input  logic [REQUESTERS*WORD_WIDTH-1:0] req_A,
  input  logic [REQUESTERS*WORD_WIDTH-1:0] req_B,
  input  logic [REQUESTERS*OP_WIDTH-1:0] req_op,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic                           rsp_result,
  output logic [FLAGS_WIDTH-1:0]         rsp_flags,
  output logic                           rsp_error
);

  logic                   r_active;
  logic [ID_WIDTH-1:0]    r_pointer;
  logic                   r_s1_valid;
  logic [WORD_WIDTH-1:0]  r_s1_a, r_s1_b;
  logic [OP_WIDTH-1:0]    r_s1_op;
  logic [ID_WIDTH-1:0]    r_s1_id;
  logic                   r_rsp_valid, r_rsp_result, r_rsp_error;
  logic [ID_WIDTH-1:0]    r_rsp_id;
  logic [FLAGS_WIDTH-1:0] r_rsp_flags;

  logic                   w_load_rsp, w_accept_ok, w_grant_valid;
  logic [REQUESTERS-1:0]  w_grant;
  logic [ID_WIDTH-1:0]    w_grant_id, w_pointer_next;
  logic [WORD_WIDTH:0]    w_diff;
  logic                   w_eq, w_lt_u, w_ovf, w_lt_s, w_error, w_result;
  logic [FLAGS_WIDTH-1:0] w_flags;

  assign w_load_rsp  = !r_rsp_valid || rsp_ready;
  assign w_accept_ok = !r_s1_valid || w_load_rsp;

  // r_active holds off grants while clear_n is low without feeding clear_n into logic.
  rr_priority_arbiter #(.REQUESTERS(REQUESTERS)) u_arbiter (
    .i_req        (req_valid),
    .i_enable     (w_accept_ok && r_active),
    .i_pointer    (r_pointer),
    .o_grant      (w_grant),
    .o_grant_id   (w_grant_id),
    .o_grant_valid(w_grant_valid)
  );

  assign req_ready      = w_grant;
  assign w_pointer_next = (w_grant_id == ID_WIDTH'(REQUESTERS - 1)) ? '0 : w_grant_id + 1'b1;

  // Predicates of A-B; the extra top bit of the difference is the unsigned borrow.
  assign w_diff  = {1'b0, r_s1_a} - {1'b0, r_s1_b};
  assign w_eq    = (w_diff[WORD_WIDTH-1:0] == '0);
  assign w_lt_u  = w_diff[WORD_WIDTH];
  assign w_ovf   = (r_s1_a[WORD_WIDTH-1] ^ r_s1_b[WORD_WIDTH-1]) &
                   (r_s1_a[WORD_WIDTH-1] ^ w_diff[WORD_WIDTH-1]);
  assign w_lt_s  = w_diff[WORD_WIDTH-1] ^ w_ovf;

  always_comb begin
    w_flags               = '0;
    w_flags[C_FLAG_EQ]    = w_eq;
    w_flags[C_FLAG_LT_U]  = w_lt_u;
    w_flags[C_FLAG_LTE_U] = w_lt_u | w_eq;
    w_flags[C_FLAG_GT_U]  = ~(w_lt_u | w_eq);
    w_flags[C_FLAG_GTE_U] = ~w_lt_u;
    w_flags[C_FLAG_LT_S]  = w_lt_s;
    w_flags[C_FLAG_LTE_S] = w_lt_s | w_eq;
    w_flags[C_FLAG_GT_S]  = ~(w_lt_s | w_eq);
    w_flags[C_FLAG_GTE_S] = ~w_lt_s;
    w_flags[C_FLAG_NE]    = ~w_eq;
  end

  assign w_error  = op_is_reserved(r_s1_op);
  assign w_result = w_error ? 1'b0 : w_flags[r_s1_op];

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_active     <= 1'b0;
      r_pointer    <= '0;
      r_s1_valid   <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= 1'b0;
      r_rsp_flags  <= '0;
      r_rsp_error  <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (w_grant_valid) r_pointer <= w_pointer_next;
      if (w_accept_ok) r_s1_valid <= w_grant_valid;
      if (w_load_rsp) begin
        r_rsp_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_rsp_id     <= r_s1_id;
          r_rsp_result <= w_result;
          r_rsp_flags  <= w_flags;
          r_rsp_error  <= w_error;
        end
      end
    end
  end

  // Operand payload needs no reset: it is qualified by r_s1_valid.
  always_ff @(posedge clock) begin
    if (w_grant_valid) begin
      r_s1_a  <= req_A[int'(w_grant_id)*WORD_WIDTH +: WORD_WIDTH];
      r_s1_b  <= req_B[int'(w_grant_id)*WORD_WIDTH +: WORD_WIDTH];
      r_s1_op <= req_op[int'(w_grant_id)*OP_WIDTH +: OP_WIDTH];
      r_s1_id <= w_grant_id;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign rsp_error  = r_rsp_error;

endmodule

`default_nettype wire

// File: tb/tb_predicate_compare_arbiter.sv
// ============================================================================
// Module      : tb_predicate_compare_arbiter
// Description : Directed self-checking bench for predicate_compare_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_predicate_compare_arbiter;
  import predicate_compare_arbiter_pkg::*;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clock = 1'b0;
  logic           clear_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_A = '0;
  logic [N*W-1:0] req_B = '0;
  logic [N*4-1:0] req_op = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [IW-1:0]  rsp_id;
  logic           rsp_result;
  logic [9:0]     rsp_flags;
  logic           rsp_error;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clock = ~clock;

  predicate_compare_arbiter #(.WORD_WIDTH(W), .REQUESTERS(N)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_A     (req_A),
    .req_B     (req_B),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result),
    .rsp_flags (rsp_flags),
    .rsp_error (rsp_error)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_client(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    req_A[i*W +: W]  = a;
    req_B[i*W +: W]  = b;
    req_op[i*4 +: 4] = op;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] hs;
    logic [3:0] exp_ready;
    logic       exp_v;
    logic [1:0] exp_id;
    int         accepts;

    // Reset: outputs cleared, no ready even with all clients valid.
    req_valid = 4'hF;
    step();
    step();
    check("rst_ready", req_ready, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_id", rsp_id, 0);
    check("rst_result", rsp_result, 0);
    check("rst_flags", rsp_flags, 0);
    check("rst_error", rsp_error, 0);
    req_valid = 4'h0;
    clear_n   = 1'b1;
    step();

    // Round robin with all four clients continuously valid.
    for (int i = 0; i < N; i++) set_client(i, 8'(i), 8'd2, C_OP_EQ);
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 11; k++) begin
      if (k == 8) begin
        req_valid = 4'h0;
        #1;
      end
      check("rr_ready", req_ready, (k < 8) ? (32'd1 << (k % 4)) : 32'd0);
      check("rr_valid", rsp_valid, (k >= 2 && k < 10) ? 32'd1 : 32'd0);
      if (k >= 2 && k < 10) begin
        check("rr_id", rsp_id, (k - 2) % 4);
        check("rr_result", rsp_result, ((k - 2) % 4 == 2) ? 32'd1 : 32'd0);
        check("rr_error", rsp_error, 0);
      end
      step();
    end

    // Client 2: 0x80 <s 0x7F.
    set_client(2, 8'h80, 8'h7F, C_OP_LT_S);
    req_valid = 4'b0100;
    #1;
    check("lts_ready", req_ready, 4'b0100);
    step();
    req_valid = 4'h0;
    check("lts_valid_t1", rsp_valid, 0);
    step();
    check("lts_valid", rsp_valid, 1);
    check("lts_id", rsp_id, 2);
    check("lts_result", rsp_result, 1);
    check("lts_error", rsp_error, 0);
    check("lts_flags", rsp_flags, 10'h278);
    check("lts_lt_u", rsp_flags[C_FLAG_LT_U], 0);
    check("lts_gt_u", rsp_flags[C_FLAG_GT_U], 1);
    step();
    check("lts_drain", rsp_valid, 0);

    // Client 1: EQ then NE on equal operands.
    set_client(1, 8'h5A, 8'h5A, C_OP_EQ);
    req_valid = 4'b0010;
    #1;
    check("eq_ready", req_ready, 4'b0010);
    step();
    set_client(1, 8'h5A, 8'h5A, C_OP_NE);
    #1;
    check("ne_ready", req_ready, 4'b0010);
    step();
    req_valid = 4'h0;
    check("eq_id", rsp_id, 1);
    check("eq_result", rsp_result, 1);
    check("eq_flags", rsp_flags, 10'h155);
    step();
    check("ne_valid", rsp_valid, 1);
    check("ne_result", rsp_result, 0);
    check("ne_flags", rsp_flags, 10'h155);
    step();
    check("ne_drain", rsp_valid, 0);

    // Back-pressure: three clients valid, rsp_ready low for five cycles.
    set_client(0, 8'd1, 8'd1, C_OP_EQ);
    set_client(1, 8'd2, 8'd1, C_OP_GT_U);
    set_client(3, 8'd3, 8'd1, C_OP_GT_U);
    req_valid = 4'b1011;
    rsp_ready = 1'b0;
    accepts   = 0;
    for (int k = 0; k < 9; k++) begin
      if (k == 5) rsp_ready = 1'b1;
      #1;
      case (k)
        0:       begin exp_ready = 4'b1000; exp_v = 1'b0; exp_id = 2'd0; end
        1:       begin exp_ready = 4'b0001; exp_v = 1'b0; exp_id = 2'd0; end
        5:       begin exp_ready = 4'b0010; exp_v = 1'b1; exp_id = 2'd3; end
        6:       begin exp_ready = 4'b0000; exp_v = 1'b1; exp_id = 2'd0; end
        7:       begin exp_ready = 4'b0000; exp_v = 1'b1; exp_id = 2'd1; end
        8:       begin exp_ready = 4'b0000; exp_v = 1'b0; exp_id = 2'd0; end
        default: begin exp_ready = 4'b0000; exp_v = 1'b1; exp_id = 2'd3; end
      endcase
      check("bp_ready", req_ready, exp_ready);
      check("bp_valid", rsp_valid, exp_v);
      if (exp_v) begin
        check("bp_id", rsp_id, exp_id);
        check("bp_result", rsp_result, 1);
        if (k >= 2 && k <= 5) check("bp_flags", rsp_flags, 10'h398);
      end
      hs = req_valid & req_ready;
      if (k < 5 && hs != 4'h0) accepts++;
      step();
      req_valid = req_valid & ~hs;
    end
    check("bp_accepts", accepts, 2);

    // Reserved opcode, then GTE_U 0x00 vs 0xFF.
    set_client(3, 8'd5, 8'd5, 4'd12);
    req_valid = 4'b1000;
    #1;
    check("rsv_ready", req_ready, 4'b1000);
    step();
    req_valid = 4'h0;
    step();
    check("rsv_valid", rsp_valid, 1);
    check("rsv_id", rsp_id, 3);
    check("rsv_error", rsp_error, 1);
    check("rsv_result", rsp_result, 0);
    check("rsv_flags", rsp_flags, 10'h155);
    set_client(3, 8'h00, 8'hFF, C_OP_GTE_U);
    req_valid = 4'b1000;
    #1;
    check("gteu_ready", req_ready, 4'b1000);
    step();
    req_valid = 4'h0;
    step();
    check("gteu_result", rsp_result, 0);
    check("gteu_error", rsp_error, 0);
    check("gteu_flags", rsp_flags, 10'h386);
    step();

    // Reset with both stages full.
    rsp_ready = 1'b0;
    set_client(1, 8'd7, 8'd7, C_OP_EQ);
    set_client(2, 8'd7, 8'd7, C_OP_EQ);
    req_valid = 4'b0110;
    #1;
    check("fill_ready1", req_ready, 4'b0010);
    step();
    req_valid = 4'b0100;
    #1;
    check("fill_ready2", req_ready, 4'b0100);
    step();
    req_valid = 4'h0;
    check("fill_valid", rsp_valid, 1);
    check("fill_id", rsp_id, 1);
    req_valid = 4'hF;
    clear_n   = 1'b0;
    #1;
    check("mrst_valid", rsp_valid, 0);
    check("mrst_id", rsp_id, 0);
    check("mrst_ready", req_ready, 0);
    step();
    req_valid = 4'h0;
    clear_n   = 1'b1;
    rsp_ready = 1'b1;
    step();
    check("post_rst_valid1", rsp_valid, 0);
    step();
    check("post_rst_valid2", rsp_valid, 0);
    set_client(0, 8'd1, 8'd2, C_OP_LT_U);
    set_client(2, 8'd1, 8'd2, C_OP_GT_U);
    req_valid = 4'b0101;
    #1;
    check("post_rst_ready0", req_ready, 4'b0001);
    step();
    req_valid = 4'b0100;
    #1;
    check("post_rst_ready2", req_ready, 4'b0100);
    step();
    req_valid = 4'h0;
    check("post_rst_id0", rsp_id, 0);
    check("post_rst_res0", rsp_result, 1);
    step();
    check("post_rst_id2", rsp_id, 2);
    check("post_rst_res2", rsp_result, 0);
    step();
    check("post_rst_drain", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
